// File: rtl/loop_nest.sv
`default_nettype none
// ============================================================================
// Module   : loop_nest
// Purpose  : Parameterised odometer-style nested loop counter (level 0 innermost).
//            Optional macro LOOP_NEST_AUTO_RESTART_EN lets a start request on the
//            final iteration relaunch without passing through IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module loop_nest #(
    parameter int DATA_W = 8,
    parameter int LEVELS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LEVELS*DATA_W-1:0] lim,
    input  logic                     start,
    input  logic                     trig,
    output logic                     busy,
    output logic [LEVELS*DATA_W-1:0] cnt,
    output logic [LEVELS-1:0]        wrap,
    output logic                     last,
    output logic                     done
);

    localparam logic [0:0]        c_idle = 1'b0;
    localparam logic [0:0]        c_run  = 1'b1;
    localparam logic [DATA_W-1:0] c_one  = DATA_W'(1);

    logic [0:0]               r_state;
    logic [0:0]               w_state_nx;
    logic [LEVELS*DATA_W-1:0] r_lim;
    logic [LEVELS*DATA_W-1:0] w_lim_nx;
    logic [LEVELS*DATA_W-1:0] r_cnt;
    logic [LEVELS*DATA_W-1:0] w_cnt_nx;
    logic [LEVELS*DATA_W-1:0] w_cnt_step;
    logic                     r_done;
    logic                     w_done_nx;
    logic                     w_run;
    logic [LEVELS-1:0]        w_eq;
    logic [LEVELS-1:0]        w_adv;

    assign w_run = (r_state == c_run);

    // Each level advances only when every inner level is at its limit.
    for (genvar gi = 0; gi < LEVELS; gi++) begin : g_lvl
        assign w_eq[gi] = (r_cnt[gi*DATA_W +: DATA_W] == r_lim[gi*DATA_W +: DATA_W]);
        if (gi == 0) begin : g_inner
            assign wrap[gi]  = w_run & w_eq[gi];
            assign w_adv[gi] = 1'b1;
        end else begin : g_outer
            assign wrap[gi]  = wrap[gi-1] & w_eq[gi];
            assign w_adv[gi] = wrap[gi-1];
        end
        assign w_cnt_step[gi*DATA_W +: DATA_W] =
            !w_adv[gi] ? r_cnt[gi*DATA_W +: DATA_W] :
            w_eq[gi]   ? '0 :
                         r_cnt[gi*DATA_W +: DATA_W] + c_one;
    end

    assign last = wrap[LEVELS-1];
    assign busy = w_run;
    assign cnt  = r_cnt;
    assign done = r_done;

    always_comb begin
        w_state_nx = r_state;
        w_lim_nx   = r_lim;
        w_cnt_nx   = r_cnt;
        w_done_nx  = 1'b0;
        if (r_state == c_idle) begin
            if (start) begin
                w_lim_nx   = lim;
                w_cnt_nx   = '0;
                w_state_nx = c_run;
            end
        end else if (trig) begin
            w_cnt_nx = w_cnt_step;
            if (last) begin
                w_cnt_nx   = '0;
                w_done_nx  = 1'b1;
                w_state_nx = c_idle;
`ifdef LOOP_NEST_AUTO_RESTART_EN
                if (start) begin
                    w_lim_nx   = lim;
                    w_state_nx = c_run;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_lim   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_lim   <= w_lim_nx;
            r_cnt   <= w_cnt_nx;
            r_done  <= w_done_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_loop_nest.sv
`default_nettype none
// ============================================================================
// Module   : tb_loop_nest
// Purpose  : Directed self-checking bench for loop_nest (LEVELS=3, DATA_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_loop_nest;

    logic        clk;
    logic        rst;
    logic [23:0] lim;
    logic        start;
    logic        trig;
    logic        busy;
    logic [23:0] cnt;
    logic [2:0]  wrap;
    logic        last;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    loop_nest #(.DATA_W(8), .LEVELS(3)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .lim   (lim),
        .start (start),
        .trig  (trig),
        .busy  (busy),
        .cnt   (cnt),
        .wrap  (wrap),
        .last  (last),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected odometer value for lim (1,2,3) after k iterations
    function automatic logic [23:0] odo(input int k);
        logic [7:0] c0, c1, c2;
        c0 = 8'(k % 4);
        c1 = 8'((k / 4) % 3);
        c2 = 8'(k / 12);
        return {c2, c1, c0};
    endfunction

    initial begin
        rst = 1'b1; lim = '0; start = 1'b0; trig = 1'b0;
        step(); step();
        chk("rst_cnt",  32'(cnt),  32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        rst = 1'b0;
        trig = 1'b1;
        step();
        chk("idle_trig_ignored", 32'(cnt), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // Full run, trig held high
        lim = {8'd1, 8'd2, 8'd3}; start = 1'b1;
        step();
        start = 1'b0;
        chk("run1_busy", 32'(busy), 32'h1);
        for (int k = 0; k < 24; k++) begin
            chk("run1_cnt",   32'(cnt),     32'(odo(k)));
            chk("run1_wrap0", 32'(wrap[0]), 32'(k % 4 == 3));
            chk("run1_last",  32'(last),    32'(k == 23));
            chk("run1_done",  32'(done),    32'h0);
            step();
        end
        chk("run1_done_pulse", 32'(done), 32'h1);
        chk("run1_busy_fall",  32'(busy), 32'h0);
        chk("run1_cnt_zero",   32'(cnt),  32'h0);
        step();
        chk("run1_done_once",  32'(done), 32'h0);

        // Alternating trig
        trig = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 24; k++) begin
            trig = 1'b1;
            chk("alt_cnt",  32'(cnt),  32'(odo(k)));
            chk("alt_last", 32'(last), 32'(k == 23));
            step();
            if (k != 23) begin
                trig = 1'b0;
                chk("alt_hold_busy", 32'(busy), 32'h1);
                step();
            end
        end
        chk("alt_done", 32'(done), 32'h1);
        chk("alt_busy", 32'(busy), 32'h0);
        step();

        // All limits zero -> single iteration
        lim = '0; start = 1'b1; trig = 1'b1;
        step();
        start = 1'b0;
        chk("zero_last", 32'(last), 32'h1);
        chk("zero_wrap", 32'(wrap), 32'h7);
        chk("zero_busy", 32'(busy), 32'h1);
        step();
        chk("zero_done", 32'(done), 32'h1);
        chk("zero_busy_fall", 32'(busy), 32'h0);
        step();
        chk("zero_done_once", 32'(done), 32'h0);
        chk("zero_idle", 32'(busy), 32'h0);

        // lim change and start pulse mid-run must be ignored
        lim = {8'd1, 8'd2, 8'd3}; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (k == 5) begin
                lim = {8'd3, 8'd3, 8'd3}; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            chk("mid_cnt",  32'(cnt),  32'(odo(k)));
            chk("mid_last", 32'(last), 32'(k == 23));
            step();
        end
        chk("mid_done", 32'(done), 32'h1);
        chk("mid_busy", 32'(busy), 32'h0);
        step();

        // Reset mid-run at cnt (0,1,2)
        lim = {8'd1, 8'd2, 8'd3}; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("abort_pre_cnt", 32'(cnt), 32'h000102);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_cnt",  32'(cnt),  32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("abort_no_done", 32'(done), 32'h0);
        end
        lim = {8'd0, 8'd0, 8'd1}; start = 1'b1;
        step();
        start = 1'b0;
        chk("fresh_cnt0",  32'(cnt),  32'h0);
        chk("fresh_last0", 32'(last), 32'h0);
        step();
        chk("fresh_cnt1",  32'(cnt),  32'h000001);
        chk("fresh_last1", 32'(last), 32'h1);
        step();
        chk("fresh_done",  32'(done), 32'h1);
        step();

        // start on the final iteration
        lim = {8'd0, 8'd1, 8'd0}; start = 1'b1;
        step();
        start = 1'b0;
        chk("ar_cnt0", 32'(cnt), 32'h0);
        step();
        chk("ar_cnt1", 32'(cnt),  32'h000100);
        chk("ar_last", 32'(last), 32'h1);
        lim = {8'd0, 8'd0, 8'd1}; start = 1'b1;
        step();
        start = 1'b0;
        chk("ar_done", 32'(done), 32'h1);
        chk("ar_cnt_zero", 32'(cnt), 32'h0);
`ifdef LOOP_NEST_AUTO_RESTART_EN
        chk("ar_busy_held", 32'(busy), 32'h1);
        chk("ar_new_last0", 32'(last), 32'h0);
        step();
        chk("ar_new_done_once", 32'(done), 32'h0);
        chk("ar_new_cnt1", 32'(cnt),  32'h000001);
        chk("ar_new_last1", 32'(last), 32'h1);
        step();
        chk("ar_new_done", 32'(done), 32'h1);
        chk("ar_new_busy", 32'(busy), 32'h0);
`else
        chk("ar_busy_low", 32'(busy), 32'h0);
        step();
        chk("ar_stay_idle", 32'(busy), 32'h0);
        chk("ar_done_once", 32'(done), 32'h0);
        chk("ar_idle_cnt",  32'(cnt),  32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
